fetch_unit: RTL and testbench

Instruction-fetch stage controller that is driven by the pipeline hazard controls: it consumes StallF, FlushD and the branch/jump target from Execute, and owns the PCF register and the Fetch/Decode pipeline register. It talks to a variable-latency instruction memory through a valid/ready request channel plus a response strobe. It delivers one instruction at a time to Decode, inserting NOP bubbles whenever memory is slow or a redirect flushes the pipe.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF and the F/D pipeline register, fetching one
// instruction at a time from a variable-latency memory over a valid/ready channel.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic [31:0] PCTargetE,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pcf_reg, pcf_next;
  logic [31:0] hold_data_reg, hold_data_next;
  logic        discard_reg, discard_next;
  logic [31:0] instr_d_reg, instr_d_next;
  logic [31:0] pcd_reg, pcd_next;
  logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;
  logic        valid_d_reg, valid_d_next;
  logic        deliver;
  logic [31:0] deliver_data;

  always_comb begin
    state_next      = state_reg;
    pcf_next        = pcf_reg;
    hold_data_next  = hold_data_reg;
    discard_next    = discard_reg;
    instr_d_next    = instr_d_reg;
    pcd_next        = pcd_reg;
    pc_plus4_d_next = pc_plus4_d_reg;
    valid_d_next    = valid_d_reg;
    deliver         = 1'b0;
    deliver_data    = ImemRespData;

    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (ImemReqReady) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (ImemRespValid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = S_REQ;
          end else if (!StallF) begin
            deliver    = 1'b1;
            state_next = S_REQ;
          end else begin
            hold_data_next = ImemRespData;
            state_next     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          deliver      = 1'b1;
          deliver_data = hold_data_reg;
          state_next   = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (deliver) begin
      instr_d_next    = deliver_data;
      pcd_next        = pcf_reg;
      pc_plus4_d_next = pcf_reg + 32'd4;
      valid_d_next    = 1'b1;
      pcf_next        = pcf_reg + 32'd4;
    end else if (!StallF) begin
      instr_d_next = NOP_INSTR;
      valid_d_next = 1'b0;
    end

    // A redirect overrides stall and delivery; an accepted-but-unanswered
    // request must have its eventual response thrown away.
    if (FlushD) begin
      pcf_next        = PCTargetE;
      hold_data_next  = hold_data_reg;
      instr_d_next    = NOP_INSTR;
      valid_d_next    = 1'b0;
      pcd_next        = pcd_reg;
      pc_plus4_d_next = pc_plus4_d_reg;
      case (state_reg)
        S_REQ: begin
          if (ImemReqReady) begin
            state_next   = S_WAIT;
            discard_next = 1'b1;
          end else begin
            state_next = S_REQ;
          end
        end
        S_WAIT: begin
          if (ImemRespValid) begin
            state_next   = S_REQ;
            discard_next = 1'b0;
          end else begin
            state_next   = S_WAIT;
            discard_next = 1'b1;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      pcf_reg        <= RESET_PC;
      hold_data_reg  <= 32'd0;
      discard_reg    <= 1'b0;
      instr_d_reg    <= NOP_INSTR;
      pcd_reg        <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_d_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pcf_reg        <= pcf_next;
      hold_data_reg  <= hold_data_next;
      discard_reg    <= discard_next;
      instr_d_reg    <= instr_d_next;
      pcd_reg        <= pcd_next;
      pc_plus4_d_reg <= pc_plus4_d_next;
      valid_d_reg    <= valid_d_next;
    end
  end

  assign ImemReqValid = (state_reg == S_REQ);
  assign ImemReqAddr  = pcf_reg;
  assign InstrD       = instr_d_reg;
  assign PCD          = pcd_reg;
  assign PCPlus4D     = pc_plus4_d_reg;
  assign ValidD       = valid_d_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, checked
// against a program-order model of the fetch stream and a one-slot memory model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, StallF, FlushD;
  logic [31:0] PCTargetE;
  logic        ImemReqValid;
  logic [31:0] ImemReqAddr;
  logic        ImemReqReady, ImemRespValid;
  logic [31:0] ImemRespData, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .FlushD(FlushD), .PCTargetE(PCTargetE),
    .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int vectors = 0, miscompares = 0, deliveries = 0;
  int ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int lat = 1;          // response latency in cycles after acceptance
  bit pend = 1'b0;
  int cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  logic [31:0] exp_pc = RESET_PC;   // address of the next instruction in program order
  bit verbose = 1'b1;
  bit found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update models, check.
  task automatic step(input logic st, input logic fl, input logic [31:0] tgt, input logic rst);
    logic [31:0] pre_instr, pre_pcd, pre_pcp4, pre_addr;
    logic        pre_valid, pre_req, acc, resp, pend_before;
    StallF = st; FlushD = fl; PCTargetE = tgt; reset = rst;
    ImemReqReady  = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    resp          = pend && (cnt == 0);
    ImemRespValid = resp;
    ImemRespData  = resp ? mem_word(pend_addr) : $urandom;
    pre_instr = InstrD; pre_pcd = PCD; pre_pcp4 = PCPlus4D; pre_valid = ValidD;
    pre_req = ImemReqValid; pre_addr = ImemReqAddr;
    acc = pre_req && ImemReqReady;
    pend_before = pend;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      pend = 1'b0;
      exp_pc = RESET_PC;
      check("rst_req_valid", ImemReqValid, 0);
      check("rst_req_addr", ImemReqAddr, RESET_PC);
      check("rst_instr", InstrD, NOP);
      check("rst_pcd", PCD, 0);
      check("rst_pcp4", PCPlus4D, 0);
      check("rst_validd", ValidD, 0);
    end else begin
      if (resp) pend = 1'b0;
      else if (pend && cnt > 0) cnt--;
      if (pre_req) check("one_outstanding", pend_before && !resp, 0);
      if (acc) begin
        pend = 1'b1; cnt = lat - 1; pend_addr = pre_addr;
      end
      if (fl) begin
        check("flush_instr", InstrD, NOP);
        check("flush_validd", ValidD, 0);
        exp_pc = tgt;
      end else if (st) begin
        check("stall_instr", InstrD, pre_instr);
        check("stall_pcd", PCD, pre_pcd);
        check("stall_pcp4", PCPlus4D, pre_pcp4);
        check("stall_validd", ValidD, pre_valid);
      end else if (ValidD) begin
        check("deliv_pcd", PCD, exp_pc);
        check("deliv_instr", InstrD, mem_word(exp_pc));
        check("deliv_pcp4", PCPlus4D, exp_pc + 32'd4);
        deliveries++;
        if (verbose) $display("deliver PCD=%h InstrD=%h PCPlus4D=%h", PCD, InstrD, PCPlus4D);
        exp_pc = exp_pc + 32'd4;
      end else begin
        check("bubble_instr", InstrD, NOP);
      end
      check("req_addr", ImemReqAddr, exp_pc);
    end
  endtask

  task automatic run_until_valid(input int max_cycles, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      if (ValidD) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCTargetE = 32'd0;
    ImemReqReady = 1'b0; ImemRespValid = 1'b0; ImemRespData = 32'd0;

    // Reset and boot: ready always high, one-cycle memory
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("boot_req_valid", ImemReqValid, 1);
    check("boot_req_addr", ImemReqAddr, 32'h0);
    check("boot_validd", ValidD, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      check("boot_gap_validd", ValidD, 0);
      check("boot_gap_req", ImemReqValid, 0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      check("boot_validd", ValidD, 1);
      check("boot_pcd", PCD, 32'(4 * k));
      check("boot_instr", InstrD, 32'(32'h100 + 4 * k));
      check("boot_next_addr", ImemReqAddr, 32'(4 * k + 4));
      check("boot_next_req", ImemReqValid, 1);
    end

    // Backpressure: request held at 0xC
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      check("bp_req_valid", ImemReqValid, 1);
      check("bp_req_addr", ImemReqAddr, 32'hC);
      check("bp_validd", ValidD, 0);
    end
    ready_mode = 1;

    // Stall while the response arrives: goes to HOLD, no new request
    step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      check("hold_no_req", ImemReqValid, 0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("hold_release_validd", ValidD, 1);
    check("hold_release_pcd", PCD, 32'hC);
    check("hold_release_instr", InstrD, 32'h10C);

    // Redirect one cycle after acceptance; stale response arrives later
    lat = 2;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("stale_dropped", ValidD, 0);
    check("redir_req_valid", ImemReqValid, 1);
    check("redir_req_addr", ImemReqAddr, 32'h200);
    run_until_valid(20, found);
    check("redir_timeout", found, 1);
    check("redir_pcd", PCD, 32'h200);

    // Flush coinciding with the response in WAIT
    lat = 1;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h300, 1'b0);
    check("flush_resp_req_valid", ImemReqValid, 1);
    check("flush_resp_req_addr", ImemReqAddr, 32'h300);
    check("flush_resp_validd", ValidD, 0);
    run_until_valid(20, found);
    check("flush_resp_timeout", found, 1);
    check("flush_resp_pcd", PCD, 32'h300);

    // Flush with stall asserted, while ValidD is high
    step(1'b1, 1'b1, 32'h400, 1'b0);
    check("flush_stall_instr", InstrD, NOP);
    check("flush_stall_validd", ValidD, 0);
    check("flush_stall_pcf", ImemReqAddr, 32'h400);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_until_valid(20, found);
    check("wrap_timeout", found, 1);
    check("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("wrap_pcp4", PCPlus4D, 32'h0);
    check("wrap_next_addr", ImemReqAddr, 32'h0);

    // Random traffic against the model
    verbose = 1'b0;
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      logic        r_rst, r_st, r_fl;
      logic [31:0] r_tgt;
      if (i % 200 == 0) lat = int'($urandom_range(1, 4));
      r_rst = ($urandom_range(0, 99) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_tgt = $urandom;
      if ($urandom_range(0, 1) == 1) r_tgt[1:0] = 2'b00;
      step(r_st, r_fl, r_tgt, r_rst);
    end
    check("random_progress", (deliveries > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
